// File: rtl/fifo_slow_ctrl.sv
// Pointer/flag controller for the slow-clock segment buffer.
// Turns a push/pop handshake into storage strobes and tracks occupancy and error flags.
`ifndef SLOW_BLK_BUFF_SIZE
`define SLOW_BLK_BUFF_SIZE 8
`endif
`ifndef BITS_SLOW_BLK_BUFF_ADDR
`define BITS_SLOW_BLK_BUFF_ADDR 3
`endif

module fifo_slow_ctrl #(
  parameter int SLOW_BLK_BUFF_SIZE      = `SLOW_BLK_BUFF_SIZE,
  parameter int BITS_SLOW_BLK_BUFF_ADDR = `BITS_SLOW_BLK_BUFF_ADDR,
  parameter int AF_MARGIN               = 2
) (
  input  logic                               clk_slow,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               push,
  output logic                               push_ready,
  input  logic                               pop,
  output logic                               pop_valid,
  output logic                               wr_en,
  output logic [BITS_SLOW_BLK_BUFF_ADDR-1:0] wr_addr,
  output logic [BITS_SLOW_BLK_BUFF_ADDR-1:0] rd_addr,
  output logic [BITS_SLOW_BLK_BUFF_ADDR:0]   count,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int B = BITS_SLOW_BLK_BUFF_ADDR;
  localparam logic [B:0] FULL_CNT = (B+1)'(SLOW_BLK_BUFF_SIZE);
  localparam logic [B:0] AF_TH    = (B+1)'(SLOW_BLK_BUFF_SIZE - AF_MARGIN);

  logic [B:0] wp_q, wp_d, rp_q, rp_d, count_d;
  logic       af_q, af_d, ovf_q, ovf_d, unf_q, unf_d;
  logic       push_acc, pop_acc;

  // Status derives from registered pointers only; the MSB wrap bit disambiguates full/empty.
  assign count      = wp_q - rp_q;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign wr_addr    = wp_q[B-1:0];
  assign rd_addr    = rp_q[B-1:0];
  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  assign push_acc = push & ~full & ~flush;
  assign pop_acc  = pop & ~empty & ~flush;
  assign wr_en    = push_acc & ~rst;

  always_comb begin
    wp_d  = wp_q + {{B{1'b0}}, push_acc};
    rp_d  = rp_q + {{B{1'b0}}, pop_acc};
    ovf_d = ovf_q | (push & full);
    unf_d = unf_q | (pop & empty);
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    count_d = wp_d - rp_d;
    // Registered from next-state count so it lines up with count exactly.
    af_d    = (count_d >= AF_TH);
  end

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      af_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      af_q  <= af_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_fifo_slow_ctrl.sv
// Directed and randomized checks of fifo_slow_ctrl (SIZE=8, AF_MARGIN=2)
// against a queue reference with a bench-side storage array.
module tb_fifo_slow_ctrl;

  logic       clk_slow, rst, flush, push, pop;
  logic       push_ready, pop_valid, wr_en, full, empty, almost_full, overflow, underflow;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] count;

  logic [15:0] mem [8];
  logic [15:0] din, dseq;
  logic [15:0] mq [$];
  logic        ovf_m, unf_m;
  logic [3:0]  wp_m, rp_m;
  int checks = 0;
  int errors = 0;

  fifo_slow_ctrl #(.SLOW_BLK_BUFF_SIZE(8), .BITS_SLOW_BLK_BUFF_ADDR(3), .AF_MARGIN(2)) dut (
    .clk_slow(clk_slow), .rst(rst), .flush(flush),
    .push(push), .push_ready(push_ready), .pop(pop), .pop_valid(pop_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  always @(posedge clk_slow) if (wr_en) mem[wr_addr] <= din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    wp_m  = '0;
    rp_m  = '0;
  endtask

  // One clock cycle: drive, check pre-edge outputs, clock, update model, check post-edge state.
  task automatic cyc(input logic p, input logic q, input logic f);
    logic pa, qa;
    push = p; pop = q; flush = f; din = dseq;
    #1;
    pa = p & (mq.size() < 8) & ~f;
    qa = q & (mq.size() > 0) & ~f;
    chk("wr_en", wr_en, pa);
    if (qa) chk("data", mem[rd_addr], mq[0]);
    @(posedge clk_slow);
    #1;
    if (f) model_clear();
    else begin
      if (p && mq.size() == 8) ovf_m = 1'b1;
      if (q && mq.size() == 0) unf_m = 1'b1;
      if (qa) begin void'(mq.pop_front()); rp_m++; end
      if (pa) begin mq.push_back(dseq); dseq++; wp_m++; end
    end
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 8);
    chk("empty", empty, mq.size() == 0);
    chk("push_ready", push_ready, mq.size() != 8);
    chk("pop_valid", pop_valid, mq.size() != 0);
    chk("almost_full", almost_full, mq.size() >= 6);
    chk("overflow", overflow, ovf_m);
    chk("underflow", underflow, unf_m);
    chk("wr_addr", wr_addr, wp_m[2:0]);
    chk("rd_addr", rd_addr, rp_m[2:0]);
  endtask

  task automatic chk_reset_vals();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_en", wr_en, 0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0; dseq = 16'h100;
    model_clear();
    #2 rst = 1'b1; push = 1'b1;
    #1 chk_reset_vals();
    push = 1'b0;
    @(negedge clk_slow) rst = 1'b0;

    // Fill: first push lands on the first edge after release.
    for (int i = 0; i < 8; i++) begin
      chk("fill_wr_addr", wr_addr, i);
      cyc(1'b1, 1'b0, 1'b0);
      chk("fill_af", almost_full, (i + 1) >= 6);
    end
    chk("full_flag", full, 1);
    chk("full_ready", push_ready, 0);
    chk("full_count", count, 8);

    cyc(1'b1, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_wr_addr", wr_addr, 0);

    for (int i = 0; i < 8; i++) begin
      chk("drain_rd_addr", rd_addr, i);
      cyc(1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("unf_set", underflow, 1);

    // Push+pop while empty: only the push takes effect.
    cyc(1'b1, 1'b1, 1'b0);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_rd_addr", rd_addr, 0);

    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("refill_count", count, 8);
    // Push+pop while full: only the pop takes effect.
    push = 1'b1; pop = 1'b1;
    #1 chk("pp_full_wr_en", wr_en, 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("pp_full_count", count, 7);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk("steady_count", count, 4);
    end

    // Flush at count 5 with overflow still set and both requests high.
    cyc(1'b1, 1'b0, 1'b0);
    chk("pre_flush_count", count, 5);
    chk("pre_flush_ovf", overflow, 1);
    push = 1'b1; pop = 1'b1; flush = 1'b1;
    #1 chk("flush_wr_en", wr_en, 0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_unf", underflow, 0);
    chk("flush_wr_addr", wr_addr, 0);
    chk("flush_rd_addr", rd_addr, 0);

    // Random traffic that honours push_ready / pop_valid.
    for (int i = 0; i < 1000; i++)
      cyc(1'($urandom_range(0, 1)) & (mq.size() < 8), 1'($urandom_range(0, 1)) & (mq.size() > 0), 1'b0);
    chk("stress_ovf", overflow, 0);
    chk("stress_unf", underflow, 0);

    // Asynchronous reset between edges at count 3.
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", count, 3);
    #3 rst = 1'b1; push = 1'b1;
    #1 chk_reset_vals();
    model_clear();
    push = 1'b0;
    @(negedge clk_slow) rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("post_rst_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_slow_ctrl.md
# fifo_slow_ctrl

Pointer and flag controller for the slow-clock segment buffer storage array. It sits between the upstream segment producer and the downstream merge consumer. It converts a push/pop handshake into the write-enable, write-address and read-address that drive the storage block, and tracks occupancy, full/empty, almost-full and sticky error flags. Storage read data is combinational on `rd_addr`, so this block defines when that data is valid.

## Interface
Parameters:
- `SLOW_BLK_BUFF_SIZE`, default `SLOW_BLK_BUFF_SIZE` macro: entry count; must be a power of two, ≥ 2.
- `BITS_SLOW_BLK_BUFF_ADDR`, default `BITS_SLOW_BLK_BUFF_ADDR` macro: log2(SIZE).
- `AF_MARGIN`, default 2: `almost_full` asserts when count ≥ SIZE − AF_MARGIN; legal range 1..SIZE−1.

Ports:
- `clk_slow` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all pointers and flags.
- `push` in 1: upstream offers one entry this cycle.
- `push_ready` out 1: space available; equals ~full.
- `pop` in 1: downstream consumes the head entry this cycle.
- `pop_valid` out 1: head entry valid at storage output; equals ~empty.
- `wr_en` out 1: storage write strobe.
- `wr_addr` out BITS_SLOW_BLK_BUFF_ADDR: storage write index.
- `rd_addr` out BITS_SLOW_BLK_BUFF_ADDR: storage read index (head).
- `count` out BITS_SLOW_BLK_BUFF_ADDR+1: occupancy, 0..SIZE.
- `full`, `empty` out 1: count==SIZE, count==0.
- `almost_full` out 1: registered threshold flag.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- State:
  - Write pointer `wp` and read pointer `rp`, each BITS+1 wide. The MSB is the wrap bit.
  - `wr_addr` = wp[BITS−1:0], `rd_addr` = rp[BITS−1:0].
  - `count` = wp − rp, modulo 2^(BITS+1).
- Accept rules, evaluated on the flags at the start of the cycle:
  - push_acc = push & ~full & ~flush.
  - pop_acc = pop & ~empty & ~flush.
- `wr_en` = push_acc, combinational. On the edge, wp += push_acc and rp += pop_acc. Pointers wrap naturally through the wrap bit.
- No bypass and no fall-through:
  - Full with push & pop both high: pop accepted, push rejected, count becomes SIZE−1.
  - Empty with push & pop both high: push accepted, pop ignored, count becomes 1.
- Errors:
  - `overflow` sets on push & full & ~flush.
  - `underflow` sets on pop & empty & ~flush.
  - Both hold until `rst` or `flush`. A rejected request never changes pointers.
- `flush` has priority over push and pop. The flush cycle drives `wr_en`=0. At the next edge, wp=rp=0 and count=0, `almost_full`=0, `overflow`=0, `underflow`=0. Storage contents are not cleared; they are stale and unreachable.
- `almost_full` is registered from next-state count, so it is exact in the same cycle as `count`.

## Timing
- Reset values (asynchronous, immediate on `rst` high):
  - wp=rp=0, `wr_addr`=`rd_addr`=0, `count`=0.
  - `empty`=1, `pop_valid`=0, `full`=0, `push_ready`=1.
  - `almost_full`=0, `overflow`=0, `underflow`=0.
  - `wr_en`=0 while `rst` is high.
- Reset release:
  - Deassertion is synchronised by the integrating level.
  - `rst` mid-operation discards all entries immediately.
  - The first push is accepted on the first edge after release.
- Write-to-read latency:
  - An entry written at edge N is presented at the storage output from cycle N+1.
  - `pop_valid` rises in cycle N+1.
- Pop:
  - The consumer samples storage `data_out` in the cycle where pop & pop_valid.
  - `rd_addr` advances at that edge.
- Outputs:
  - `push_ready`, `pop_valid`, `full`, `empty`, `count` are derived from registered pointers only. No combinational path from `push` or `pop`.
  - The only combinational input-to-output path is `wr_en`.
- Throughput is one push and one pop per cycle, sustained, when neither full nor empty.

## Test plan
All scenarios use SIZE=8, AF_MARGIN=2.
- Reset then 8 pushes, no pops:
  - `wr_addr` goes 0..7.
  - `almost_full` rises after the 6th push (count=6).
  - After 8 pushes: `full`=1, `push_ready`=0, count=8.
  - A 9th push sets `overflow`=1; count and wp are unchanged.
- From full, 8 pops:
  - `rd_addr` goes 0..7 and data matches push order.
  - Ends `empty`=1, count=0.
  - A further pop sets `underflow`=1.
- Simultaneous push+pop:
  - At count=8: count becomes 7, `wr_en`=0.
  - At count=0: count becomes 1, `rd_addr` stays 0.
  - At count=4 for 20 cycles: count stays 4 and both addresses wrap 7→0.
- Wrap stress:
  - 1000 random push/pop cycles against a reference queue model.
  - count, full, empty and data order match every cycle.
  - No overflow or underflow while requests respect `push_ready` and `pop_valid`.
- Flush at count=5 with push=pop=1 and `overflow` set:
  - `wr_en`=0 in the flush cycle.
  - Next cycle: count=0, `empty`=1, `overflow`=0, addresses 0.
- Async reset asserted mid-cycle at count=3, between edges:
  - All outputs reach reset values before the next clock edge.
